// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge port of the memory-access stage.
// The stage drives the master side; the memory (or bench) drives the slave side.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [63:0] dmem_addr;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_ack;
  logic [63:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ack, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack port with byte-lane
// steering and load extension, and emits one registered MEMWB record per retire.
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] exmm_aluresult,
  input  logic [63:0] EXMEM_rs2,
  input  logic [5:0]  dest_reg,
  input  logic        mem_active,
  input  logic        load,
  input  logic [7:0]  ldst_size,
  input  logic        ld_unsigned,
  input  logic        EXMEM_ready,
  input  logic        EXMEM_wbactive,
  input  logic        EXMEM_ecall,
  output logic        MEMEX_stall,
  output logic [5:0]  MEMEX_rd,
  output logic [63:0] MEMEX_rdval,
  output logic        MEMEX_wbactive,
  mem_stage_if.master dmem,
  output logic        MEMWB_ready,
  output logic [5:0]  MEMWB_rd,
  output logic [63:0] MEMWB_rdval,
  output logic        MEMWB_wbactive,
  output logic        MEMWB_ecall,
  output logic        mem_fault
);

  localparam int unsigned XLEN = 64;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state_q, state_d;

  logic            accept_alu, accept_mem, accept_bad, retire_mem;
  logic            size_ok, align_ok;
  logic [7:0]      byte_mask;
  logic [1:0]      size_code;
  logic [2:0]      lane_in;

  logic [XLEN-1:0] addr_q, wdata_q, load_shift, load_val;
  logic [7:0]      wstrb_q;
  logic            we_q, load_q, uns_q, wb_q;
  logic [1:0]      size_q;
  logic [2:0]      lane_q;
  logic [5:0]      rd_q;

  assign lane_in = exmm_aluresult[2:0];

  // Access-size decode and natural-alignment check
  always_comb begin
    size_ok   = 1'b1;
    align_ok  = 1'b0;
    byte_mask = 8'h00;
    size_code = 2'd0;
    case (ldst_size)
      8'd8:  begin byte_mask = 8'h01; size_code = 2'd0; align_ok = 1'b1;                end
      8'd16: begin byte_mask = 8'h03; size_code = 2'd1; align_ok = ~lane_in[0];         end
      8'd32: begin byte_mask = 8'h0F; size_code = 2'd2; align_ok = (lane_in[1:0] == 2'd0); end
      8'd64: begin byte_mask = 8'hFF; size_code = 2'd3; align_ok = (lane_in == 3'd0);   end
      default: size_ok = 1'b0;
    endcase
  end

  // Next-state and retire/accept strobes
  always_comb begin
    state_d    = state_q;
    accept_alu = 1'b0;
    accept_mem = 1'b0;
    accept_bad = 1'b0;
    retire_mem = 1'b0;
    case (state_q)
      IDLE: begin
        if (EXMEM_ready) begin
          if (!mem_active) begin
            accept_alu = 1'b1;
          end else if (size_ok && align_ok) begin
            accept_mem = 1'b1;
            state_d    = BUSY;
          end else begin
            accept_bad = 1'b1;
          end
        end
      end
      BUSY: begin
        if (dmem.dmem_ack) begin
          retire_mem = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Load lane alignment, truncation and extension
  always_comb begin
    load_shift = dmem.dmem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'd0:    load_val = {{56{~uns_q & load_shift[7]}},  load_shift[7:0]};
      2'd1:    load_val = {{48{~uns_q & load_shift[15]}}, load_shift[15:0]};
      2'd2:    load_val = {{32{~uns_q & load_shift[31]}}, load_shift[31:0]};
      default: load_val = load_shift;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Captured request and MEMWB record registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q         <= '0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      we_q           <= 1'b0;
      load_q         <= 1'b0;
      uns_q          <= 1'b0;
      wb_q           <= 1'b0;
      size_q         <= 2'd0;
      lane_q         <= 3'd0;
      rd_q           <= '0;
      MEMWB_ready    <= 1'b0;
      MEMWB_rd       <= '0;
      MEMWB_rdval    <= '0;
      MEMWB_wbactive <= 1'b0;
      MEMWB_ecall    <= 1'b0;
      mem_fault      <= 1'b0;
    end else begin
      MEMWB_ready    <= 1'b0;
      MEMWB_wbactive <= 1'b0;
      MEMWB_ecall    <= 1'b0;
      mem_fault      <= 1'b0;
      if (accept_alu) begin
        MEMWB_ready    <= 1'b1;
        MEMWB_rd       <= dest_reg;
        MEMWB_rdval    <= exmm_aluresult;
        MEMWB_wbactive <= EXMEM_wbactive & (|dest_reg);
        MEMWB_ecall    <= EXMEM_ecall;
      end
      if (accept_bad) begin
        MEMWB_ready <= 1'b1;
        MEMWB_rd    <= dest_reg;
        mem_fault   <= 1'b1;
      end
      if (accept_mem) begin
        addr_q  <= {exmm_aluresult[XLEN-1:3], 3'b000};
        we_q    <= ~load;
        wdata_q <= load ? '0 : (EXMEM_rs2 << {lane_in, 3'b000});
        wstrb_q <= load ? 8'h00 : (byte_mask << lane_in);
        load_q  <= load;
        uns_q   <= ld_unsigned;
        size_q  <= size_code;
        lane_q  <= lane_in;
        rd_q    <= dest_reg;
        wb_q    <= load & EXMEM_wbactive & (|dest_reg);
      end
      if (retire_mem) begin
        MEMWB_ready    <= 1'b1;
        MEMWB_rd       <= rd_q;
        MEMWB_wbactive <= wb_q;
        if (load_q) MEMWB_rdval <= load_val;
      end
    end
  end

  assign dmem.dmem_req   = (state_q == BUSY);
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

  assign MEMEX_stall    = (state_q == BUSY);
  assign MEMEX_rd       = MEMWB_rd;
  assign MEMEX_rdval    = MEMWB_rdval;
  assign MEMEX_wbactive = MEMWB_ready & MEMWB_wbactive;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single ops plus hand-written
// reset-mid-access and back-to-back load sequences.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] exmm_aluresult, EXMEM_rs2;
  logic [5:0]  dest_reg;
  logic        mem_active, load, ld_unsigned, EXMEM_ready, EXMEM_wbactive, EXMEM_ecall;
  logic [7:0]  ldst_size;
  logic        MEMEX_stall, MEMEX_wbactive;
  logic [5:0]  MEMEX_rd;
  logic [63:0] MEMEX_rdval;
  logic        MEMWB_ready, MEMWB_wbactive, MEMWB_ecall, mem_fault;
  logic [5:0]  MEMWB_rd;
  logic [63:0] MEMWB_rdval;

  mem_stage_if dmem ();

  mem_stage dut (
    .clk(clk), .reset(reset),
    .exmm_aluresult(exmm_aluresult), .EXMEM_rs2(EXMEM_rs2), .dest_reg(dest_reg),
    .mem_active(mem_active), .load(load), .ldst_size(ldst_size), .ld_unsigned(ld_unsigned),
    .EXMEM_ready(EXMEM_ready), .EXMEM_wbactive(EXMEM_wbactive), .EXMEM_ecall(EXMEM_ecall),
    .MEMEX_stall(MEMEX_stall), .MEMEX_rd(MEMEX_rd), .MEMEX_rdval(MEMEX_rdval),
    .MEMEX_wbactive(MEMEX_wbactive), .dmem(dmem.master),
    .MEMWB_ready(MEMWB_ready), .MEMWB_rd(MEMWB_rd), .MEMWB_rdval(MEMWB_rdval),
    .MEMWB_wbactive(MEMWB_wbactive), .MEMWB_ecall(MEMWB_ecall), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          mem, ld, uns;
    logic [7:0]  size;
    logic [63:0] addr, rs2;
    logic [5:0]  rd;
    bit          wb, ec;
    logic [63:0] rdata;
    int          k;
    bit          e_fault, e_we;
    logic [7:0]  e_strb;
    logic [63:0] e_addr, e_wdata, e_rdval;
    bit          e_wb;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit mem, bit ld, bit uns, logic [7:0] size, logic [63:0] addr,
                              logic [63:0] rs2, logic [5:0] rd, bit wb, bit ec,
                              logic [63:0] rdata, int k, bit e_fault, bit e_we,
                              logic [7:0] e_strb, logic [63:0] e_addr, logic [63:0] e_wdata,
                              logic [63:0] e_rdval, bit e_wb);
    vec_t v;
    v.mem = mem; v.ld = ld; v.uns = uns; v.size = size; v.addr = addr; v.rs2 = rs2;
    v.rd = rd; v.wb = wb; v.ec = ec; v.rdata = rdata; v.k = k; v.e_fault = e_fault;
    v.e_we = e_we; v.e_strb = e_strb; v.e_addr = e_addr; v.e_wdata = e_wdata;
    v.e_rdval = e_rdval; v.e_wb = e_wb;
    return v;
  endfunction

  task automatic drive_rec(input bit mem, input bit ld, input bit uns, input logic [7:0] size,
                           input logic [63:0] addr, input logic [63:0] rs2,
                           input logic [5:0] rd, input bit wb, input bit ec);
    mem_active = mem; load = ld; ld_unsigned = uns; ldst_size = size;
    exmm_aluresult = addr; EXMEM_rs2 = rs2; dest_reg = rd;
    EXMEM_wbactive = wb; EXMEM_ecall = ec; EXMEM_ready = 1'b1;
  endtask

  vec_t vt[13];
  int   stall_cnt;
  int   rcnt;
  int   rcyc[2];
  logic [63:0] rval[2];
  int   rec, run;
  bit   will_accept;
  bit   saw_ready;

  initial begin
    //          mem ld uns size   addr          rs2                    rd wb ec rdata                  k  flt we strb   e_addr        e_wdata                e_rdval                e_wb
    vt[0]  = mk(0, 0, 0, 8'd0,  64'h1234,      64'h0,                 5, 1, 0, 64'h0,                0, 0, 0, 8'h00, 64'h0,        64'h0,                 64'h1234,              1);
    vt[1]  = mk(0, 0, 0, 8'd0,  64'hDEAD,      64'h0,                 0, 1, 1, 64'h0,                0, 0, 0, 8'h00, 64'h0,        64'h0,                 64'hDEAD,              0);
    vt[2]  = mk(1, 1, 0, 8'd8,  64'h1003,      64'h0,                 7, 1, 0, 64'h0000_0000_8000_0000, 3, 0, 0, 8'h00, 64'h1000, 64'h0,                 64'hFFFF_FFFF_FFFF_FF80, 1);
    vt[3]  = mk(1, 1, 1, 8'd8,  64'h1003,      64'h0,                 8, 1, 0, 64'h0000_0000_8000_0000, 3, 0, 0, 8'h00, 64'h1000, 64'h0,                 64'h80,                1);
    vt[4]  = mk(1, 0, 0, 8'd16, 64'h2006,      64'hBEEF,              9, 1, 0, 64'h0,                1, 0, 1, 8'hC0, 64'h2000,     64'hBEEF_0000_0000_0000, 64'h0,               0);
    vt[5]  = mk(1, 1, 0, 8'd32, 64'h1002,      64'h0,                 4, 1, 0, 64'h0,                0, 1, 0, 8'h00, 64'h0,        64'h0,                 64'h0,                 0);
    vt[6]  = mk(1, 1, 0, 8'd64, 64'h3000,      64'h0,                10, 1, 0, 64'h1122_3344_5566_7788, 2, 0, 0, 8'h00, 64'h3000, 64'h0,                 64'h1122_3344_5566_7788, 1);
    vt[7]  = mk(1, 1, 0, 8'd16, 64'h4002,      64'h0,                11, 1, 0, 64'h0000_0000_F00D_0000, 1, 0, 0, 8'h00, 64'h4000, 64'h0,                 64'hFFFF_FFFF_FFFF_F00D, 1);
    vt[8]  = mk(1, 1, 1, 8'd32, 64'h5004,      64'h0,                12, 1, 0, 64'h8765_4321_0000_0000, 2, 0, 0, 8'h00, 64'h5000, 64'h0,                 64'h0000_0000_8765_4321, 1);
    vt[9]  = mk(1, 0, 0, 8'd64, 64'h6008,      64'h0102_0304_0506_0708, 0, 0, 0, 64'h0,              1, 0, 1, 8'hFF, 64'h6008,     64'h0102_0304_0506_0708, 64'h0,               0);
    vt[10] = mk(1, 0, 0, 8'd8,  64'h7005,      64'hAB,                0, 0, 0, 64'h0,                2, 0, 1, 8'h20, 64'h7000,     64'h0000_AB00_0000_0000, 64'h0,                0);
    vt[11] = mk(1, 1, 0, 8'd24, 64'h8000,      64'h0,                13, 1, 0, 64'h0,                0, 1, 0, 8'h00, 64'h0,        64'h0,                 64'h0,                 0);
    vt[12] = mk(1, 0, 0, 8'd32, 64'h9006,      64'h55,                0, 0, 0, 64'h0,                0, 1, 1, 8'h00, 64'h0,        64'h0,                 64'h0,                 0);

    reset = 1'b0;
    drive_rec(0, 0, 0, 8'd0, 64'h0, 64'h0, 0, 0, 0);
    EXMEM_ready = 1'b0;
    dmem.dmem_ack = 1'b0;
    dmem.dmem_rdata = '0;
    #12;
    chk("rst_req", 64'(dmem.dmem_req), 64'd0);
    chk("rst_stall", 64'(MEMEX_stall), 64'd0);
    chk("rst_ready", 64'(MEMWB_ready), 64'd0);
    chk("rst_fault", 64'(mem_fault), 64'd0);
    chk("rst_rdval", MEMWB_rdval, 64'd0);
    chk("rst_addr", dmem.dmem_addr, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Table of single operations
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive_rec(vt[i].mem, vt[i].ld, vt[i].uns, vt[i].size, vt[i].addr, vt[i].rs2,
                vt[i].rd, vt[i].wb, vt[i].ec);
      @(posedge clk); #1;
      EXMEM_ready = 1'b0;
      if (!vt[i].mem) begin
        chk($sformatf("v%0d_ready", i), 64'(MEMWB_ready), 64'd1);
        chk($sformatf("v%0d_rd", i), 64'(MEMWB_rd), 64'(vt[i].rd));
        chk($sformatf("v%0d_rdval", i), MEMWB_rdval, vt[i].e_rdval);
        chk($sformatf("v%0d_fwdval", i), MEMEX_rdval, vt[i].e_rdval);
        chk($sformatf("v%0d_wb", i), 64'(MEMWB_wbactive), 64'(vt[i].e_wb));
        chk($sformatf("v%0d_fwdwb", i), 64'(MEMEX_wbactive), 64'(vt[i].e_wb));
        chk($sformatf("v%0d_ecall", i), 64'(MEMWB_ecall), 64'(vt[i].ec));
        chk($sformatf("v%0d_stall", i), 64'(MEMEX_stall), 64'd0);
      end else if (vt[i].e_fault) begin
        chk($sformatf("v%0d_fault", i), 64'(mem_fault), 64'd1);
        chk($sformatf("v%0d_ready", i), 64'(MEMWB_ready), 64'd1);
        chk($sformatf("v%0d_wb", i), 64'(MEMWB_wbactive), 64'd0);
        chk($sformatf("v%0d_req", i), 64'(dmem.dmem_req), 64'd0);
        chk($sformatf("v%0d_stall", i), 64'(MEMEX_stall), 64'd0);
      end else begin
        chk($sformatf("v%0d_req", i), 64'(dmem.dmem_req), 64'd1);
        chk($sformatf("v%0d_addr", i), dmem.dmem_addr, vt[i].e_addr);
        chk($sformatf("v%0d_we", i), 64'(dmem.dmem_we), 64'(vt[i].e_we));
        chk($sformatf("v%0d_strb", i), 64'(dmem.dmem_wstrb), 64'(vt[i].e_strb));
        if (!vt[i].ld) chk($sformatf("v%0d_wdata", i), dmem.dmem_wdata, vt[i].e_wdata);
        stall_cnt = 0;
        for (int c = 1; c <= vt[i].k; c++) begin
          @(negedge clk);
          if (MEMEX_stall) stall_cnt++;
          dmem.dmem_ack = (c == vt[i].k);
          dmem.dmem_rdata = vt[i].rdata;
          if (c == vt[i].k) chk($sformatf("v%0d_addr_hold", i), dmem.dmem_addr, vt[i].e_addr);
          @(posedge clk); #1;
          dmem.dmem_ack = 1'b0;
        end
        chk($sformatf("v%0d_stallcnt", i), 64'(stall_cnt), 64'(vt[i].k));
        chk($sformatf("v%0d_stall_end", i), 64'(MEMEX_stall), 64'd0);
        chk($sformatf("v%0d_ready", i), 64'(MEMWB_ready), 64'd1);
        chk($sformatf("v%0d_rd", i), 64'(MEMWB_rd), 64'(vt[i].rd));
        if (vt[i].ld) chk($sformatf("v%0d_rdval", i), MEMWB_rdval, vt[i].e_rdval);
        chk($sformatf("v%0d_wb", i), 64'(MEMWB_wbactive), 64'(vt[i].e_wb));
        chk($sformatf("v%0d_fwdwb", i), 64'(MEMEX_wbactive), 64'(vt[i].e_wb));
        chk($sformatf("v%0d_fault", i), 64'(mem_fault), 64'd0);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_ready_pulse", i), 64'(MEMWB_ready), 64'd0);
      chk($sformatf("v%0d_fault_pulse", i), 64'(mem_fault), 64'd0);
    end

    // Reset asserted between edges while a load is outstanding
    @(negedge clk);
    drive_rec(1, 1, 0, 8'd64, 64'hA000, 64'h0, 3, 1, 0);
    @(posedge clk); #1;
    EXMEM_ready = 1'b0;
    chk("rstbusy_req_pre", 64'(dmem.dmem_req), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rstbusy_req", 64'(dmem.dmem_req), 64'd0);
    chk("rstbusy_stall", 64'(MEMEX_stall), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dmem.dmem_ack = 1'b1;
    dmem.dmem_rdata = 64'hFFFF_0000_FFFF_0000;
    saw_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      dmem.dmem_ack = 1'b0;
      if (MEMWB_ready) saw_ready = 1'b1;
    end
    chk("rstbusy_stray_ack", 64'(saw_ready), 64'd0);

    // Two loads held by execute through the stall, each acked a cycle after req
    rec = 0; run = 0; rcnt = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (dmem.dmem_req) run++; else run = 0;
      dmem.dmem_ack = (run == 2);
      dmem.dmem_rdata = {dmem.dmem_addr[31:0], ~dmem.dmem_addr[31:0]};
      if (rec == 0)      drive_rec(1, 1, 0, 8'd64, 64'h100, 64'h0, 14, 1, 0);
      else if (rec == 1) drive_rec(1, 1, 0, 8'd64, 64'h208, 64'h0, 15, 1, 0);
      else               EXMEM_ready = 1'b0;
      will_accept = (rec < 2) && !MEMEX_stall;
      @(posedge clk); #1;
      if (will_accept) rec++;
      if (MEMWB_ready && rcnt < 2) begin
        rcyc[rcnt] = cyc;
        rval[rcnt] = MEMWB_rdval;
        rcnt++;
      end
    end
    dmem.dmem_ack = 1'b0;
    EXMEM_ready = 1'b0;
    chk("b2b_count", 64'(rcnt), 64'd2);
    if (rcnt == 2) begin
      chk("b2b_gap", 64'(rcyc[1] - rcyc[0]), 64'd3);
      chk("b2b_val0", rval[0], 64'h0000_0100_FFFF_FEFF);
      chk("b2b_val1", rval[1], 64'h0000_0208_FFFF_FDF7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage RISC-V pipeline. It sits between the execute stage and writeback and consumes the execute stage's EXMEM outputs. Loads and stores go over a req/ack data-memory port, with byte-lane steering and sign/zero extension. The stage returns the MEMEX stall and forwarding signals to execute and presents one registered MEMWB record per retired instruction.

## Interface
- No parameters; XLEN fixed at 64.
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-low reset
- exmm_aluresult  in  64  ALU result, or effective address when mem_active
- EXMEM_rs2  in  64  store data
- dest_reg  in  6  destination register
- mem_active  in  1  load/store instruction
- load  in  1  1 = load, 0 = store (valid when mem_active)
- ldst_size  in  8  access width in bits: 8/16/32/64
- ld_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
- EXMEM_ready  in  1  execute record valid this cycle
- EXMEM_wbactive  in  1  instruction writes rd
- EXMEM_ecall  in  1  ecall marker
- MEMEX_stall  out  1  execute must hold its record
- MEMEX_rd  out  6  forwarding destination
- MEMEX_rdval  out  64  forwarding value
- MEMEX_wbactive  out  1  forwarding valid
- dmem_req  out  1  memory request
- dmem_we  out  1  write enable
- dmem_addr  out  64  8-byte-aligned address ({addr[63:3],3'b0})
- dmem_wdata  out  64  lane-shifted store data
- dmem_wstrb  out  8  byte strobes
- dmem_ack  in  1  request complete (1-cycle pulse)
- dmem_rdata  in  64  read data, valid with dmem_ack
- MEMWB_ready  out  1  writeback record valid (1-cycle pulse)
- MEMWB_rd  out  6  writeback destination
- MEMWB_rdval  out  64  writeback value
- MEMWB_wbactive  out  1  writeback enable
- MEMWB_ecall  out  1  ecall marker to writeback
- mem_fault  out  1  misaligned or bad-size access (1-cycle pulse)

## Operation
- States are IDLE and BUSY. Accept condition: posedge in IDLE with EXMEM_ready=1.
- Non-memory accept (mem_active=0):
  - MEMWB_ready=1 next cycle.
  - MEMWB_rd=dest_reg, MEMWB_rdval=exmm_aluresult, MEMWB_ecall=EXMEM_ecall.
  - MEMWB_wbactive=EXMEM_wbactive, forced to 0 when dest_reg=0.
- Memory accept, legal case (ldst_size ∈ {8,16,32,64} and addr mod (ldst_size/8)=0):
  - Register address, size, store data, rd, load and ld_unsigned; go to BUSY.
  - lane = addr[2:0]; bytes = ldst_size/8.
  - Store: dmem_wdata = rs2 << (8·lane); dmem_wstrb = ((1<<bytes)-1) << lane; dmem_we=1.
  - Load: dmem_we=0, dmem_wstrb=0.
- Memory accept, illegal case (misaligned or bad size):
  - No request is issued.
  - Next cycle: mem_fault=1, MEMWB_ready=1, MEMWB_wbactive=0.
- BUSY:
  - dmem_req=1; dmem_addr, dmem_we, dmem_wdata and dmem_wstrb held stable until the ack edge.
  - On dmem_ack: go to IDLE and emit the MEMWB record next cycle.
  - Load value: d = dmem_rdata >> (8·lane), truncated to ldst_size bits, then sign-extended (ld_unsigned=0) or zero-extended (ld_unsigned=1). ldst_size=64 takes no extension.
  - Stores retire with MEMWB_wbactive=0.
- dmem_ack in IDLE is ignored.
- MEMEX_stall = (state==BUSY), combinational. Execute holds its record; the held record is re-presented and accepted at the first IDLE edge.
- Forwarding outputs: MEMEX_rd=MEMWB_rd, MEMEX_rdval=MEMWB_rdval, MEMEX_wbactive=MEMWB_ready & MEMWB_wbactive.
- Cycles with no retirement: MEMWB_ready=0, MEMWB_wbactive=0, MEMWB_ecall=0. rd/rdval hold their last values.

## Timing
- Reset (reset=0, asynchronous):
  - State IDLE.
  - All outputs 0, including dmem_req, MEMEX_stall, MEMWB_* and mem_fault.
  - An in-flight request drops immediately.
  - A dmem_ack arriving after reset release is ignored.
- Non-memory latency: accepted at edge T → MEMWB_ready high in cycle T..T+1.
- Memory latency:
  - Accepted at edge T → dmem_req high from T.
  - Ack sampled at edge T+k (k≥1) → MEMWB_ready high T+k..T+k+1.
  - MEMEX_stall is high exactly k cycles.
- Throughput: one non-memory instruction per cycle.
- Back-to-back memory ops: the second request's dmem_req rises at the edge after the first ack, so dmem_req shows a one-cycle gap.
- Simultaneous events: EXMEM_ready=1 during BUSY is not accepted; it is retained by execute via the stall.

## Test plan
- add record (aluresult=0x1234, rd=5, wbactive=1) → next cycle MEMWB_ready=1, rd=5, rdval=0x1234, MEMEX_wbactive=1; MEMEX_stall stays 0.
- lb at addr 0x1003, dmem_rdata=0x0000_0000_8000_0000, ack 3 cycles after accept → dmem_addr=0x1000, stall high 3 cycles, rdval=0xFFFF_FFFF_FFFF_FF80. Same with ld_unsigned=1 → rdval=0x80.
- sh at addr 0x2006, rs2=0xBEEF → dmem_we=1, dmem_wstrb=0xC0, dmem_wdata[63:48]=0xBEEF; retire with MEMWB_wbactive=0.
- lw at addr 0x1002 → dmem_req never rises; mem_fault=1 and MEMWB_ready=1 for one cycle, MEMWB_wbactive=0.
- reset driven to 0 mid-BUSY, between clock edges → dmem_req and MEMEX_stall drop before the next edge. A later ack after reset release produces no MEMWB_ready.
- Two consecutive ld ops, each acked after 1 cycle → two MEMWB_ready pulses 3 cycles apart, each with the correct rdval.
